// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings and depth derivation.
package fifo_pkg;

  // Values carried by the FWFT parameter.
  localparam int FWFT_STD  = 0;  // registered read, rd_valid pulses after a pop
  localparam int FWFT_FALL = 1;  // head word presented continuously

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write; registered read (FWFT_STD) or combinational read (FWFT_FALL).
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FWFT_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; stale words stay hidden behind the count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (FWFT == FWFT_FALL) begin : g_fwft
    assign rd_data = mem[rd_addr];
    logic unused_rd;
    assign unused_rd = ^{rst, rd_en};
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem[rd_addr];
    end
    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, sticky error flags and optional FWFT.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FWFT_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;
  logic                  wr_accept, rd_accept;

  // All flags come from the registered count, so they settle one cycle after an accepted op.
  assign fifo_full    = (count_q == DEPTH_CNT);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign fill_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_accept = wr_en & ~fifo_full;
  assign rd_accept = rd_en & ~fifo_empty;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error event outranks a coincident clear.
    ovf_d = (wr_en & fifo_full)  | (ovf_q & ~clr_err);
    udf_d = (rd_en & fifo_empty) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  if (FWFT == FWFT_FALL) begin : g_valid_fwft
    assign rd_valid = ~fifo_empty;
  end else begin : g_valid_std
    logic rd_valid_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_valid_q <= 1'b0;
      else     rd_valid_q <= rd_accept;
    end
    assign rd_valid = rd_valid_q;
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a registered-read instance and a first-word-fall-through instance.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] af_thresh, ae_thresh;

  // Registered-read instance
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] fill_count;

  // FWFT instance
  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .fill_count(fill_count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .fill_count(f_count), .overflow(f_ovf),
    .underflow(f_udf), .clr_err(f_clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = 8'h00;

    // Reset state
    #7;
    check("rst_empty",    32'(fifo_empty),   32'd1);
    check("rst_full",     32'(fifo_full),    32'd0);
    check("rst_ovf",      32'(overflow),     32'd0);
    check("rst_udf",      32'(underflow),    32'd0);
    check("rst_valid",    32'(rd_valid),     32'd0);
    check("rst_rdata",    32'(rd_data),      32'h00);
    check("rst_count",    32'(fill_count),   32'd0);
    check("rst_ae",       32'(almost_empty), 32'd1);
    check("rst_af",       32'(almost_full),  32'd0);
    check("rst_f_empty",  32'(f_empty),      32'd1);
    check("rst_f_valid",  32'(f_rd_valid),   32'd0);
    rst = 1'b0;

    // FWFT: write on the first edge after reset, head appears without rd_en
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    check("fwft_valid",   32'(f_rd_valid), 32'd1);
    check("fwft_data",    32'(f_rd_data),  32'hA5);
    check("fwft_count",   32'(f_count),    32'd1);
    f_wr_en = 1'b1; f_wr_data = 8'h5A;
    tick();
    f_wr_en = 1'b0;
    check("fwft_head",    32'(f_rd_data),  32'hA5);
    f_rd_en = 1'b1;
    tick();
    check("fwft_pop1",    32'(f_rd_data),  32'h5A);
    check("fwft_pop1_v",  32'(f_rd_valid), 32'd1);
    tick();
    f_rd_en = 1'b0;
    check("fwft_empty",   32'(f_empty),    32'd1);
    check("fwft_novalid", 32'(f_rd_valid), 32'd0);

    // Fill 0x00..0x0F with threshold crossings
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      check("fill_count", 32'(fill_count), 32'(i + 1));
      if (i == 10) check("af_below", 32'(almost_full),  32'd0);
      if (i == 11) check("af_rise",  32'(almost_full),  32'd1);
      if (i == 2)  check("ae_at3",   32'(almost_empty), 32'd1);
      if (i == 3)  check("ae_at4",   32'(almost_empty), 32'd0);
    end
    check("full_set",     32'(fifo_full), 32'd1);
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("ovf_set",      32'(overflow),   32'd1);
    check("ovf_count",    32'(fill_count), 32'd16);
    check("ovf_full",     32'(fifo_full),  32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_clr",      32'(overflow),   32'd0);

    // Drain in order, one cycle after each rd_en
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain_valid", 32'(rd_valid),   32'd1);
      check("drain_data",  32'(rd_data),    32'(i));
      check("drain_count", 32'(fill_count), 32'(15 - i));
      if (i == 11) check("ae_at4_drain", 32'(almost_empty), 32'd0);
      if (i == 12) check("ae_at3_drain", 32'(almost_empty), 32'd1);
    end
    tick();
    check("udf_empty",    32'(fifo_empty), 32'd1);
    check("udf_set",      32'(underflow),  32'd1);
    check("udf_novalid",  32'(rd_valid),   32'd0);
    check("udf_hold",     32'(rd_data),    32'h0F);
    clr_err = 1'b1;
    tick();
    rd_en = 1'b0; clr_err = 1'b0;
    check("udf_set_wins", 32'(underflow),  32'd1);

    // Simultaneous push/pop at count 8; pointers wrap
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'(8'h80 + i);
      tick();
    end
    check("sim_pre_count", 32'(fill_count), 32'd8);
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data = 8'(8'h88 + k);
      tick();
      check("sim_data",  32'(rd_data),    32'(8'h80 + k));
      check("sim_count", 32'(fill_count), 32'd8);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("tail_data", 32'(rd_data), 32'(8'h94 + k));
    end
    rd_en = 1'b0;
    check("tail_count",   32'(fill_count), 32'd5);
    check("udf_sticky",   32'(underflow),  32'd1);

    // Asynchronous reset mid-operation
    #3;
    rst = 1'b1;
    #1;
    check("mrst_empty",   32'(fifo_empty), 32'd1);
    check("mrst_count",   32'(fill_count), 32'd0);
    check("mrst_udf",     32'(underflow),  32'd0);
    check("mrst_full",    32'(fifo_full),  32'd0);
    check("mrst_valid",   32'(rd_valid),   32'd0);
    check("mrst_rdata",   32'(rd_data),    32'h00);
    check("mrst_f_empty", 32'(f_empty),    32'd1);
    #2;
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    check("post_count",   32'(fill_count), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_data",    32'(rd_data),    32'h3C);
    check("post_valid",   32'(rd_valid),   32'd1);
    check("post_empty",   32'(fifo_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
